mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl.sv | 101 ++++++++++
 tb/tb_mult_div_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multi-cycle MIPS-style HI/LO multiply/divide unit with a fixed busy latency.
// Operands are latched at launch; HI/LO change only on completion or on mthi/mtlo in IDLE.
module mult_div_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  md_op,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        busy
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      r_state, w_state_n;
    logic [CW-1:0] r_cnt, w_cnt_n;
    logic [31:0] r_a, r_b, r_hi, r_lo, w_hi_n, w_lo_n;
    logic [1:0]  r_op;
    logic        w_load;
    logic        w_sgn;
    logic [63:0] w_ea, w_eb, w_prod;
    logic [31:0] w_abs_a, w_abs_b, w_q, w_r, w_quo, w_rem;

    // One 64-bit multiplier serves both: sign-extension selects signed vs unsigned.
    assign w_sgn   = ~r_op[0];
    assign w_ea    = {{32{w_sgn & r_a[31]}}, r_a};
    assign w_eb    = {{32{w_sgn & r_b[31]}}, r_b};
    assign w_prod  = w_ea * w_eb;
    // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    assign w_abs_a = (w_sgn & r_a[31]) ? -r_a : r_a;
    assign w_abs_b = (w_sgn & r_b[31]) ? -r_b : r_b;
    assign w_q     = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a / w_abs_b;
    assign w_r     = (w_abs_b == 32'd0) ? 32'd0 : w_abs_a % w_abs_b;
    assign w_quo   = (w_sgn & (r_a[31] ^ r_b[31])) ? -w_q : w_q;
    assign w_rem   = (w_sgn & r_a[31]) ? -w_r : w_r;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_hi_n    = r_hi;
        w_lo_n    = r_lo;
        w_load    = 1'b0;
        if (r_state == IDLE) begin
            if (start) begin
                w_load    = 1'b1;
                w_state_n = BUSY;
                w_cnt_n   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end else begin
                w_hi_n = mthi ? A : r_hi;
                w_lo_n = mtlo ? A : r_lo;
            end
        end else begin
            w_cnt_n = r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                w_state_n = IDLE;
                if (!r_op[1]) begin
                    w_hi_n = w_prod[63:32];
                    w_lo_n = w_prod[31:0];
                end else if (r_b != 32'd0) begin
                    w_hi_n = w_rem;
                    w_lo_n = w_quo;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_hi    <= w_hi_n;
            r_lo    <= w_lo_n;
            if (w_load) begin
                r_a  <= A;
                r_b  <= B;
                r_op <= md_op;
            end
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;
    assign busy   = (r_state == BUSY);
endmodule

// File: tb/tb_mult_div_ctrl.sv
// tb_mult_div_ctrl: directed self-checking bench for mult_div_ctrl.
module tb_mult_div_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  md_op = 2'b00;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [31:0] hi_out, lo_out;
    logic        busy;
    int checks = 0;
    int failures = 0;

    mult_div_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .mthi(mthi), .mtlo(mtlo), .A(A), .B(B),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output bit held);
        logic [31:0] h0, l0;
        @(negedge clk);
        start = 1'b1; md_op = op; A = a; B = b;
        h0 = hi_out; l0 = lo_out;
        @(negedge clk);
        start = 1'b0; A = ~a; B = b + 32'd1;
        held = 1'b1;
        cycles = 0;
        while (busy && cycles < 100) begin
            cycles++;
            if (hi_out !== h0 || lo_out !== l0) held = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h want=0", busy); end
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL reset_hi got=%08h want=00000000", hi_out); end
        checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL reset_lo got=%08h want=00000000", lo_out); end
        reset = 1'b0;
    endtask

    task automatic test_mult;
        int n; bit h;
        run_op(2'b00, 32'hFFFFFFFE, 32'd3, n, h);
        checks++; if (n !== 5) begin failures++; $display("FAIL mult_cycles got=%0d want=5", n); end
        checks++; if (h !== 1'b1) begin failures++; $display("FAIL mult_hold got=%0d want=1", h); end
        checks++; if (hi_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%08h want=ffffffff", hi_out); end
        checks++; if (lo_out !== 32'hFFFFFFFA) begin failures++; $display("FAIL mult_lo got=%08h want=fffffffa", lo_out); end
        run_op(2'b01, 32'hFFFFFFFE, 32'd3, n, h);
        checks++; if (n !== 5) begin failures++; $display("FAIL multu_cycles got=%0d want=5", n); end
        checks++; if (hi_out !== 32'h2) begin failures++; $display("FAIL multu_hi got=%08h want=00000002", hi_out); end
        checks++; if (lo_out !== 32'hFFFFFFFA) begin failures++; $display("FAIL multu_lo got=%08h want=fffffffa", lo_out); end
    endtask

    task automatic test_div;
        int n; bit h;
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, n, h);
        checks++; if (n !== 10) begin failures++; $display("FAIL div_cycles got=%0d want=10", n); end
        checks++; if (h !== 1'b1) begin failures++; $display("FAIL div_hold got=%0d want=1", h); end
        checks++; if (lo_out !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%08h want=fffffffd", lo_out); end
        checks++; if (hi_out !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%08h want=ffffffff", hi_out); end
        run_op(2'b11, 32'hFFFFFFF9, 32'd2, n, h);
        checks++; if (n !== 10) begin failures++; $display("FAIL divu_cycles got=%0d want=10", n); end
        checks++; if (lo_out !== 32'h7FFFFFFC) begin failures++; $display("FAIL divu_lo got=%08h want=7ffffffc", lo_out); end
        checks++; if (hi_out !== 32'h1) begin failures++; $display("FAIL divu_hi got=%08h want=00000001", hi_out); end
    endtask

    task automatic test_div_zero;
        int n; bit h;
        @(negedge clk); mthi = 1'b1; A = 32'h11;
        @(negedge clk); mthi = 1'b0; mtlo = 1'b1; A = 32'h22;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%0h want=0", busy); end
        @(negedge clk); mtlo = 1'b0;
        checks++; if (hi_out !== 32'h11 || lo_out !== 32'h22) begin failures++; $display("FAIL mtx_setup got=%08h/%08h want=00000011/00000022", hi_out, lo_out); end
        run_op(2'b11, 32'd1234, 32'd0, n, h);
        checks++; if (n !== 10) begin failures++; $display("FAIL div0_cycles got=%0d want=10", n); end
        checks++; if (hi_out !== 32'h11) begin failures++; $display("FAIL div0_hi got=%08h want=00000011", hi_out); end
        checks++; if (lo_out !== 32'h22) begin failures++; $display("FAIL div0_lo got=%08h want=00000022", lo_out); end
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, n, h);
        checks++; if (lo_out !== 32'h80000000) begin failures++; $display("FAIL divovf_lo got=%08h want=80000000", lo_out); end
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL divovf_hi got=%08h want=00000000", hi_out); end
    endtask

    task automatic test_ignore_busy;
        int k;
        @(negedge clk); start = 1'b1; md_op = 2'b00; A = 32'd6; B = 32'd7;
        @(negedge clk); start = 1'b0;
        k = 0;
        while (busy && k < 100) begin
            k++;
            start = (k >= 3); mthi = (k >= 3); mtlo = (k == 5);
            md_op = 2'b10; A = 32'h55; B = 32'h3;
            @(negedge clk);
        end
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checks++; if (k !== 5) begin failures++; $display("FAIL ign_cycles got=%0d want=5", k); end
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL ign_hi got=%08h want=00000000", hi_out); end
        checks++; if (lo_out !== 32'd42) begin failures++; $display("FAIL ign_lo got=%08h want=0000002a", lo_out); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ign_nostart got=%0h want=0", busy); end
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL ign_hi2 got=%08h want=00000000", hi_out); end
        mthi = 1'b1; A = 32'hAB;
        @(negedge clk); mthi = 1'b0;
        checks++; if (hi_out !== 32'hAB) begin failures++; $display("FAIL mthi_hi got=%08h want=000000ab", hi_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy2 got=%0h want=0", busy); end
        checks++; if (lo_out !== 32'd42) begin failures++; $display("FAIL mthi_lo got=%08h want=0000002a", lo_out); end
    endtask

    task automatic test_start_priority;
        int n;
        @(negedge clk); start = 1'b1; mtlo = 1'b1; md_op = 2'b00; A = 32'd4; B = 32'd5;
        @(negedge clk); start = 1'b0; mtlo = 1'b0;
        n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); end
        checks++; if (n !== 5) begin failures++; $display("FAIL prio_cycles got=%0d want=5", n); end
        checks++; if (lo_out !== 32'h14) begin failures++; $display("FAIL prio_lo got=%08h want=00000014", lo_out); end
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL prio_hi got=%08h want=00000000", hi_out); end
    endtask

    task automatic test_async_reset;
        int n; bit h;
        @(negedge clk); start = 1'b1; md_op = 2'b10; A = 32'd100; B = 32'd7;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ar_prebusy got=%0h want=1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ar_busy got=%0h want=0", busy); end
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL ar_hi got=%08h want=00000000", hi_out); end
        checks++; if (lo_out !== 32'h0) begin failures++; $display("FAIL ar_lo got=%08h want=00000000", lo_out); end
        @(negedge clk); reset = 1'b0;
        repeat (12) @(negedge clk);
        checks++; if (hi_out !== 32'h0 || lo_out !== 32'h0) begin failures++; $display("FAIL ar_discard got=%08h/%08h want=0/0", hi_out, lo_out); end
        run_op(2'b01, 32'h10, 32'h10, n, h);
        checks++; if (n !== 5) begin failures++; $display("FAIL ar_cycles got=%0d want=5", n); end
        checks++; if (lo_out !== 32'h100) begin failures++; $display("FAIL ar_lo2 got=%08h want=00000100", lo_out); end
        checks++; if (hi_out !== 32'h0) begin failures++; $display("FAIL ar_hi2 got=%08h want=00000000", hi_out); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset;
        test_mult;
        test_div;
        test_div_zero;
        test_ignore_busy;
        test_start_priority;
        test_async_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
